// File: rtl/bcd_digit_chain.sv
// bcd_digit_chain
//
// Cascade of DIGITS BCD digit counters for the stopwatch datapath. Each digit
// counts modulo 10 or modulo 6, selected per digit by MOD6_MASK. The chain
// counts up or down. It accepts a manual single-step pulse while stopped, and
// pulses carry_out when the whole chain wraps.
//
// Parameters:
//   DIGITS     number of digits (1..8); digit 0 is least significant
//   MOD6_MASK  bit i = 1 -> digit i counts 0..5, bit i = 0 -> digit i counts 0..9
//
// Ports:
//   clk        clock; all state changes on its rising edge
//   rst        asynchronous reset, active-high
//   stay       run enable; one step per clock while high
//   add        manual step request; rising edge honoured only while stay = 0
//   down       direction; 0 = up, 1 = down (sampled on the step clock)
//   clear      synchronous clear of all digits (highest priority)
//   count      registered digit values, digit i in bits [4i+3:4i]
//   carry_out  registered one-cycle pulse, aligned with the wrapped count
//
// Optional feature, enabled by defining BCD_LAP_DISPLAY_EN:
//   lap        input; while high, display freezes and count keeps running
//   display    registered copy of count, one cycle behind, frozen by lap

module bcd_digit_chain #(
  parameter int unsigned       DIGITS    = 4,
  parameter logic [DIGITS-1:0] MOD6_MASK = DIGITS'(4'b1000)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stay,
  input  logic                add,
  input  logic                down,
  input  logic                clear,
`ifdef BCD_LAP_DISPLAY_EN
  input  logic                lap,
  output logic [4*DIGITS-1:0] display,
`endif
  output logic [4*DIGITS-1:0] count,
  output logic                carry_out
);

  // Largest legal value of digit i.
  function automatic logic [3:0] digit_max(input int unsigned i);
    return MOD6_MASK[i] ? 4'd5 : 4'd9;
  endfunction

  logic                add_q;
  logic                step;
  logic [4*DIGITS-1:0] count_q, count_d;
  logic                carry_q, carry_d;

  logic [DIGITS-1:0]   at_max;
  logic [DIGITS-1:0]   at_zero;
  logic [DIGITS-1:0]   dig_en;
  logic                all_term;

  // A manual step fires on the first clock add is seen high. add_q tracks add
  // even while running, so add held across the stay falling edge stays inert.
  assign step = stay | (add & ~add_q & ~stay);

  // Per-digit terminal flags and the ripple enable chain. Digit i steps when
  // every lower digit sits at its terminal value for the current direction.
  // The chain value after the last digit means the whole chain is terminal.
  always_comb begin : enable_chain
    logic chain;
    chain   = 1'b1;
    at_max  = '0;
    at_zero = '0;
    dig_en  = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      at_max[i]  = (count_q[4*i +: 4] == digit_max(i));
      at_zero[i] = (count_q[4*i +: 4] == 4'd0);
      dig_en[i]  = chain;
      chain      = chain & (down ? at_zero[i] : at_max[i]);
    end
    all_term = chain;
  end

  // Next-state: clear > step > hold.
  always_comb begin
    count_d = count_q;
    carry_d = 1'b0;
    if (clear) begin
      count_d = '0;
    end else if (step) begin
      carry_d = all_term;
      for (int i = 0; i < int'(DIGITS); i++) begin
        if (dig_en[i]) begin
          if (!down) begin
            count_d[4*i +: 4] = at_max[i] ? 4'd0 : count_q[4*i +: 4] + 4'd1;
          end else begin
            count_d[4*i +: 4] = at_zero[i] ? digit_max(i) : count_q[4*i +: 4] - 4'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      carry_q <= 1'b0;
      add_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      carry_q <= carry_d;
      add_q   <= add;
    end
  end

  assign count     = count_q;
  assign carry_out = carry_q;

`ifdef BCD_LAP_DISPLAY_EN
  logic [4*DIGITS-1:0] display_q, display_d;

  // Display trails count by one register stage; lap holds the last value.
  always_comb begin
    display_d = display_q;
    if (clear) begin
      display_d = '0;
    end else if (!lap) begin
      display_d = count_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      display_q <= '0;
    end else begin
      display_q <= display_d;
    end
  end

  assign display = display_q;
`endif

endmodule

// File: tb/tb_bcd_digit_chain.sv
module tb_bcd_digit_chain;

  localparam int unsigned DIGITS = 4;
  localparam logic [DIGITS-1:0] MASK = 4'b1000;
  localparam int CW = 4 * DIGITS;

  function automatic int modulus();
    int m;
    m = 1;
    for (int i = 0; i < int'(DIGITS); i++) m = m * (MASK[i] ? 6 : 10);
    return m;
  endfunction

  localparam int MODULUS = modulus();

  // Mixed-radix integer to packed BCD.
  function automatic logic [CW-1:0] to_bcd(input int v);
    logic [CW-1:0] r;
    int rad;
    r = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      rad = MASK[i] ? 6 : 10;
      r[4*i +: 4] = 4'(v % rad);
      v = v / rad;
    end
    return r;
  endfunction

  logic clk, rst, stay, add, down, clear;
  logic [CW-1:0] count;
  logic carry_out;
`ifdef BCD_LAP_DISPLAY_EN
  logic lap;
  logic [CW-1:0] display;
`endif

  bcd_digit_chain #(.DIGITS(DIGITS), .MOD6_MASK(MASK)) dut (
    .clk      (clk),
    .rst      (rst),
    .stay     (stay),
    .add      (add),
    .down     (down),
    .clear    (clear),
`ifdef BCD_LAP_DISPLAY_EN
    .lap      (lap),
    .display  (display),
`endif
    .count    (count),
    .carry_out(carry_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [CW-1:0] cnt;
    logic          cy;
    logic [CW-1:0] disp;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_fail = 0;

  // Reference model state.
  int            mv = 0;
  logic          m_add_q = 1'b0;
  logic [CW-1:0] md = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, push the model's prediction, compare after the edge.
  task automatic cycle(input logic s, input logic a, input logic d, input logic c);
    logic stp;
    logic [CW-1:0] prev;
    exp_t e;
    exp_t got_e;
    logic ok;
    stay = s; add = a; down = d; clear = c;
    prev = to_bcd(mv);
    stp = s | (a & ~m_add_q & ~s);
    e.cy = 1'b0;
    if (c) begin
      mv = 0;
    end else if (stp) begin
      if (!d) begin
        e.cy = (mv == MODULUS - 1);
        mv = (mv + 1) % MODULUS;
      end else begin
        e.cy = (mv == 0);
        mv = (mv == 0) ? MODULUS - 1 : mv - 1;
      end
    end
    m_add_q = a;
`ifdef BCD_LAP_DISPLAY_EN
    if (c) md = '0;
    else if (!lap) md = prev;
`endif
    e.cnt = to_bcd(mv);
    e.disp = md;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got_e = sb.pop_front();
    check("count", count, got_e.cnt);
    check("carry_out", carry_out, got_e.cy);
`ifdef BCD_LAP_DISPLAY_EN
    check("display", display, got_e.disp);
`endif
    ok = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++)
      if (count[4*i +: 4] >= (MASK[i] ? 4'd6 : 4'd10)) ok = 1'b0;
    check("digit_range", ok, 1'b1);
  endtask

  task automatic run(input int n, input logic s, input logic a, input logic d);
    for (int k = 0; k < n; k++) cycle(s, a, d, 1'b0);
  endtask

  initial begin
    rst = 1'b1; stay = 0; add = 0; down = 0; clear = 0;
`ifdef BCD_LAP_DISPLAY_EN
    lap = 1'b0;
`endif
    #12;
    check("reset_count", count, 16'h0000);
    check("reset_carry", carry_out, 1'b0);
    rst = 1'b0;

    // Run 137 steps then reset asynchronously between edges.
    run(137, 1'b1, 1'b0, 1'b0);
    check("run137", count, 16'h0137);
    #2 rst = 1'b1;
    #1;
    check("async_rst_count", count, 16'h0000);
    check("async_rst_carry", carry_out, 1'b0);
    mv = 0; m_add_q = 1'b0; md = '0;
    #3 rst = 1'b0;

    // Mixed-modulus up wrap.
    run(5999, 1'b1, 1'b0, 1'b0);
    check("pre_wrap", count, 16'h5999);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    check("wrap_count", count, 16'h0000);
    check("wrap_carry", carry_out, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check("wrap_carry_one_clock", carry_out, 1'b0);

    // Down borrow from 0100, then down wrap from 0000.
    run(100, 1'b1, 1'b0, 1'b0);
    check("at_0100", count, 16'h0100);
    cycle(1'b1, 1'b0, 1'b1, 1'b0);
    check("borrow", count, 16'h0099);
    check("borrow_carry", carry_out, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b1, 1'b0);
    check("down_wrap", count, 16'h5999);
    check("down_wrap_carry", carry_out, 1'b1);

    // Manual step: held add gives one step; three pulses give three more.
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    run(5, 1'b0, 1'b1, 1'b0);
    check("add_held", count, 16'h0001);
    for (int p = 0; p < 3; p++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b1, 1'b0, 1'b0);
    end
    check("add_pulses", count, 16'h0004);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    // add during run, then held across the stay falling edge: no extra step.
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    check("add_while_run", count, 16'h0005);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    check("add_across_stay_fall", count, 16'h0005);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0);
    check("add_down", count, 16'h0004);

    // Clear beats step at 5999.
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b1, 1'b0);
    check("pre_clear", count, 16'h5999);
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    check("clear_count", count, 16'h0000);
    check("clear_carry", carry_out, 1'b0);

`ifdef BCD_LAP_DISPLAY_EN
    run(42, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check("lap_pre", display, 16'h0042);
    lap = 1'b1;
    run(10, 1'b1, 1'b0, 1'b0);
    check("lap_hold_disp", display, 16'h0042);
    check("lap_hold_count", count, 16'h0052);
    lap = 1'b0;
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    check("lap_rel_count", count, 16'h0053);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check("lap_rel_disp", display, 16'h0053);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check("clear_disp", display, 16'h0000);
`endif

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule

// File: doc/bcd_digit_chain.md
# bcd_digit_chain

Parametrised cascade of BCD digit counters for the stopwatch datapath, replacing the separate per-digit counter modules (centesimas, decimas, seconds units, and so on) with one block. It holds `DIGITS` decimal digits; each digit has modulus 10 or 6, selected per digit. The chain counts up or down, accepts a manual single-step pulse while stopped, and flags whole-chain wrap. It sits between the timebase tick generator and the display multiplexer.

## Interface
- `DIGITS`, default 4: number of BCD digits; digit 0 is least significant. Valid range 1–8.
- `MOD6_MASK`, default 4'b1000 (`DIGITS` bits): bit i = 1 gives digit i modulus 6 (range 0–5); bit i = 0 gives modulus 10 (range 0–9).

Ports:
- `clk`  in  1: single clock; all state changes on its rising edge.
- `rst`  in  1: asynchronous reset, active-high; clears all state immediately.
- `stay`  in  1: run enable; while 1, the chain steps once per clock.
- `add`  in  1: manual step request; honoured only while `stay`=0, rising-edge detected internally.
- `down`  in  1: direction; 0 counts up, 1 counts down.
- `clear`  in  1: synchronous clear of all digits.
- `count`  out  4*DIGITS: digit values, digit i in bits [4i+3:4i]; registered.
- `carry_out`  out  1: one-cycle pulse on whole-chain wrap; registered.

## Operation
- **Reset:** while `rst`=1, `count`=0, `carry_out`=0, internal `add_q`=0. Reset asserted mid-count aborts the count immediately; no partial step survives.
- **Step event:** `step` = `stay` | (`add` & ~`add_q` & ~`stay`). `add_q` samples `add` every clock, including while `stay`=1. This means an `add` held high across a `stay` falling edge does not cause a step.
- **Priority per clock:** `clear` > `step` > hold.
  - `clear`=1 forces all digits to 0 and `carry_out`=0, regardless of `step`.
- **Up step:**
  - Digit 0 always steps.
  - Digit i>0 steps only when all lower digits are at their maximum (9 or 5).
  - A stepping digit at its maximum goes to 0; otherwise it increments by 1.
- **Down step:**
  - Digit i>0 steps only when all lower digits are 0.
  - A stepping digit at 0 goes to its maximum; otherwise it decrements by 1.
- **Wrap detection:** `carry_out` goes to 1 on the clock where a step occurs and every digit is at its terminal value before the step. The terminal value is the maximum when counting up and 0 when counting down. Otherwise `carry_out` goes to 0.
- **Direction change:** `down` is sampled on the step clock only; toggling between steps is legal with no extra state.
- **Illegal digit values:** cannot arise, since the only load value is 0. Verification must assert every digit stays within its modulus.

## Timing
- **Latency:** `count` reflects a step on the same rising edge at which `step` is evaluated true (one register stage). `carry_out` is aligned with the wrapped `count` value.
- **Rate:** with `stay`=1, one step per clock. Upstream gates `stay` with the timebase tick, so "clock" means tick-qualified clock.
- **Manual step:** `add` rising at edge k (seen as `add`=1, `add_q`=0) steps at edge k. Holding `add` high produces no further steps; `add` must return low for ≥1 clock to re-arm.
- **Ripple:** enable terms are combinational from the current `count`. The worst-case path is the `DIGITS`-wide AND chain, with no multi-cycle paths.

## Configuration
- **`BCD_LAP_DISPLAY_EN` defined:**
  - Adds input `lap` (1 bit) and output `display` (4*DIGITS).
  - `lap`=0: `display` follows `count` with one cycle of register delay.
  - `lap`=1: `display` freezes at its current value while `count` keeps counting.
  - `lap` falling edge resumes following on the next clock.
  - `rst` and `clear` both force `display`=0.
- **Undefined:** no `lap`/`display` ports or display register; the consumer uses `count` directly.

## Test plan
- **Reset mid-count:** `DIGITS`=4, mask 4'b1000, `stay`=1 from 0 for 137 clocks, then assert `rst` asynchronously between edges → `count`=0 immediately, `carry_out`=0.
- **Mixed-modulus up wrap:** preload via 5999 steps (count = 5,9,9,9 → 16'h5999), one more step → `count`=16'h0000, `carry_out`=1 for exactly one clock.
- **Down borrow and wrap:**
  - From 16'h0100, `down`=1, one step → 16'h0099.
  - From 16'h0000, one step → 16'h5999 with `carry_out`=1.
- **Manual step:**
  - `stay`=0, hold `add`=1 for 5 clocks → count +1 only.
  - Pulse `add` 3 separate times → total +4.
  - `add`=1 while `stay`=1 gives no extra step.
- **Clear priority:** `clear`=1 and `stay`=1 in the same clock at 16'h5999 → `count`=0, `carry_out`=0.
- **`BCD_LAP_DISPLAY_EN`:** run to 16'h0042, assert `lap` for 10 clocks → `display` holds 16'h0042 while `count` reaches 16'h0052. Release `lap` → `display`=16'h0053 one clock after `count` reaches it.
